obj_motion_ctrl: RTL and testbench

- Per-frame sequencer for the on-screen object position (o_x, o_y) used by the VGA object/border renderer.
- Samples debounced direction buttons, or runs an autonomous bounce, once per frame at the start of vertical sync.
- Computes and clamps the next position, then commits it in a single cycle so the renderer never sees a half-updated pair.
- Replaces the free-running prescaler update with frame-locked motion.

---
 rtl/obj_motion_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_obj_motion_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_motion_ctrl.sv
// rtl/obj_motion_ctrl.sv - frame-locked object position sequencer for the VGA object renderer
module obj_motion_ctrl #(
    parameter logic [9:0] X_INIT     = 10'd320,
    parameter logic [9:0] Y_INIT     = 10'd240,
    parameter logic [9:0] X_MIN      = 10'd10,
    parameter logic [9:0] X_MAX      = 10'd600,
    parameter logic [9:0] Y_MIN      = 10'd10,
    parameter logic [9:0] Y_MAX      = 10'd440,
    parameter int         DEB_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vs,
    input  logic [3:0] btn,
    input  logic       auto_mode,
    input  logic [2:0] step,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       upd,
    output logic       dir_x,
    output logic       dir_y
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        CALC_X = 3'd2,
        CALC_Y = 3'd3,
        COMMIT = 3'd4
    } state_t;

    // Button bit positions: {right, left, dn, up}
    localparam int B_UP    = 0;
    localparam int B_DN    = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;

    localparam logic [2:0] DEB_TH = 3'(DEB_FRAMES);

    // Signed 11-bit bounds so that subtraction near zero never wraps
    localparam logic signed [10:0] X_LO = $signed({1'b0, X_MIN});
    localparam logic signed [10:0] X_HI = $signed({1'b0, X_MAX});
    localparam logic signed [10:0] Y_LO = $signed({1'b0, Y_MIN});
    localparam logic signed [10:0] Y_HI = $signed({1'b0, Y_MAX});

    state_t      state;
    state_t      state_nxt;

    logic        vs_q;
    logic        tick;
    logic [3:0]  btn_s1;
    logic [3:0]  btn_s2;
    logic [2:0]  btn_cnt     [4];
    logic [2:0]  btn_cnt_nxt [4];
    logic [3:0]  pressed;
    logic [3:0]  pressed_nxt;
    logic        auto_l;
    logic [2:0]  step_l;
    logic [9:0]  nx;
    logic [9:0]  ny;
    logic [10:0] x_res;
    logic [10:0] y_res;

    // One axis step: returns {new_dir, new_pos}. Bounce mode flips the
    // direction only when the raw result overshoots a bound; landing
    // exactly on a bound keeps the direction.
    function automatic logic [10:0] axis_next(
        input logic [9:0]         pos,
        input logic [2:0]         stp,
        input logic               am,
        input logic               dir,
        input logic               inc,
        input logic               dec,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        logic signed [10:0] p;
        logic signed [10:0] s;
        logic signed [10:0] n;
        logic               d;
        p = $signed({1'b0, pos});
        s = $signed({8'd0, stp});
        d = dir;
        if (am) begin
            n = dir ? (p + s) : (p - s);
        end else if (inc && !dec) begin
            n = p + s;
        end else if (dec && !inc) begin
            n = p - s;
        end else begin
            n = p;
        end
        if (n > hi) begin
            n = hi;
            if (am) d = 1'b0;
        end else if (n < lo) begin
            n = lo;
            if (am) d = 1'b1;
        end
        return {d, n[9:0]};
    endfunction

    assign tick = vs_q & ~vs;

    // Debounce counters advance once per frame; pressed is judged on the updated count
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            btn_cnt_nxt[i] = 3'd0;
            if (btn_s2[i]) begin
                btn_cnt_nxt[i] = (btn_cnt[i] == 3'd7) ? 3'd7 : btn_cnt[i] + 3'd1;
            end
            pressed_nxt[i] = (btn_cnt_nxt[i] >= DEB_TH);
        end
    end

    // Candidate positions for the current frame from the committed values
    always_comb begin
        x_res = axis_next(o_x, step_l, auto_l, dir_x,
                          pressed[B_RIGHT], pressed[B_LEFT], X_LO, X_HI);
        y_res = axis_next(o_y, step_l, auto_l, dir_y,
                          pressed[B_DN], pressed[B_UP], Y_LO, Y_HI);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and the commit pulse
    always_comb begin
        state_nxt = state;
        upd       = 1'b0;
        case (state)
            IDLE:    if (tick) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = CALC_X;
            CALC_X:  state_nxt = CALC_Y;
            CALC_Y:  state_nxt = COMMIT;
            COMMIT: begin
                state_nxt = IDLE;
                upd       = (nx != o_x) || (ny != o_y);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input synchronizers and vsync edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 4'd0;
            btn_s2 <= 4'd0;
            vs_q   <= 1'b1;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            vs_q   <= vs;
        end
    end

    // Per-frame datapath: sample, compute each axis, then commit both together
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                btn_cnt[i] <= 3'd0;
            end
            pressed <= 4'd0;
            auto_l  <= 1'b0;
            step_l  <= 3'd0;
            nx      <= X_INIT;
            ny      <= Y_INIT;
            o_x     <= X_INIT;
            o_y     <= Y_INIT;
            dir_x   <= 1'b1;
            dir_y   <= 1'b1;
        end else begin
            case (state)
                SAMPLE: begin
                    for (int i = 0; i < 4; i++) begin
                        btn_cnt[i] <= btn_cnt_nxt[i];
                    end
                    pressed <= pressed_nxt;
                    auto_l  <= auto_mode;
                    step_l  <= step;
                end
                CALC_X: begin
                    nx    <= x_res[9:0];
                    dir_x <= x_res[10];
                end
                CALC_Y: begin
                    ny    <= y_res[9:0];
                    dir_y <= y_res[10];
                end
                COMMIT: begin
                    o_x <= nx;
                    o_y <= ny;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_obj_motion_ctrl.sv
// tb/tb_obj_motion_ctrl.sv - scoreboard bench for obj_motion_ctrl
module tb_obj_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs;
    logic [3:0] btn;
    logic       auto_mode;
    logic [2:0] step;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       upd;
    logic       dir_x;
    logic       dir_y;

    obj_motion_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .vs        (vs),
        .btn       (btn),
        .auto_mode (auto_mode),
        .step      (step),
        .o_x       (o_x),
        .o_y       (o_y),
        .upd       (upd),
        .dir_x     (dir_x),
        .dir_y     (dir_y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   upd_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int x, input int y, input int dx, input int dy);
        exp_t e;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.dx = dx[0];
        e.dy = dy[0];
        exp_q.push_back(e);
    endtask

    // Monitor: every upd pulse must match the next expected commit
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (upd === 1'b1) begin
                upd_cnt++;
                chk("upd_latency", 32'(cyc - fall_cyc), 32'd4);
                @(negedge clk);
                chk("upd_width", {31'd0, upd}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_upd: got o_x=%0d o_y=%0d expected no update", o_x, o_y);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_x", {22'd0, o_x}, {22'd0, e.x});
                    chk("commit_y", {22'd0, o_y}, {22'd0, e.y});
                    chk("commit_dir_x", {31'd0, dir_x}, {31'd0, e.dx});
                    chk("commit_dir_y", {31'd0, dir_y}, {31'd0, e.dy});
                end
            end
        end
    end

    // One frame: vs high, then low for low_len cycles. action 1 changes step
    // in the CALC_X cycle, action 2 pulses rst in the CALC_Y cycle.
    task automatic frame(input int low_len, input int action);
        repeat (10) @(negedge clk);
        vs = 1'b0;
        fall_cyc = cyc;
        if (action == 1) begin
            repeat (2) @(negedge clk);
            step = 3'd7;
            repeat (low_len - 2) @(negedge clk);
        end else if (action == 2) begin
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (low_len - 4) @(negedge clk);
        end else begin
            repeat (low_len) @(negedge clk);
        end
        vs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int uc;
        int mx, my, mdx, mdy, nx, ny;

        rst = 1'b1; vs = 1'b1; btn = 4'd0; auto_mode = 1'b0; step = 3'd0;

        // Reset with vs toggling: no update, reset values held
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            vs = ~vs;
            @(negedge clk);
            chk("reset_upd", {31'd0, upd}, 32'd0);
        end
        chk("reset_x", {22'd0, o_x}, 32'd320);
        chk("reset_y", {22'd0, o_y}, 32'd240);
        chk("reset_dir_x", {31'd0, dir_x}, 32'd1);
        chk("reset_dir_y", {31'd0, dir_y}, 32'd1);
        vs = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_upd_cnt", 32'(upd_cnt), 32'd0);

        // Debounce: right held, step 3
        btn = 4'b1000; step = 3'd3;
        repeat (5) @(negedge clk);
        frame(20, 0);
        chk("deb_frame1_cnt", 32'(upd_cnt), 32'd0);
        chk("deb_frame1_x", {22'd0, o_x}, 32'd320);
        push_exp(323, 240, 1, 1);
        frame(20, 0);
        chk("deb_frame2_x", {22'd0, o_x}, 32'd323);
        push_exp(326, 240, 1, 1);
        frame(20, 0);
        chk("deb_frame3_x", {22'd0, o_x}, 32'd326);

        // Walk to 598: 38 frames of +7, one of +6
        step = 3'd7;
        for (int i = 1; i <= 38; i++) begin
            push_exp(326 + 7 * i, 240, 1, 1);
            frame(20, 0);
        end
        step = 3'd6;
        push_exp(598, 240, 1, 1);
        frame(20, 0);
        chk("walk_x", {22'd0, o_x}, 32'd598);

        // Clamp at X_MAX
        step = 3'd7;
        push_exp(600, 240, 1, 1);
        frame(20, 0);
        chk("clamp_x", {22'd0, o_x}, 32'd600);
        uc = upd_cnt;
        frame(20, 0);
        chk("clamp_hold_x", {22'd0, o_x}, 32'd600);
        chk("clamp_hold_upd", 32'(upd_cnt), 32'(uc));

        // Left only, then left+right conflict
        btn = 4'b0100; step = 3'd3;
        uc = upd_cnt;
        frame(20, 0);
        chk("left_deb_upd", 32'(upd_cnt), 32'(uc));
        push_exp(597, 240, 1, 1);
        frame(20, 0);
        btn = 4'b1100;
        push_exp(594, 240, 1, 1);
        frame(20, 0);
        uc = upd_cnt;
        frame(20, 0);
        chk("conflict_x", {22'd0, o_x}, 32'd594);
        chk("conflict_upd", 32'(upd_cnt), 32'(uc));

        // Step changed during CALC_X: the latched step 3 applies
        btn = 4'b1000; step = 3'd3;
        push_exp(597, 240, 1, 1);
        frame(20, 1);
        chk("midstep_x", {22'd0, o_x}, 32'd597);

        // Reset during CALC_Y aborts the commit
        step = 3'd3;
        uc = upd_cnt;
        frame(20, 2);
        chk("midrst_x", {22'd0, o_x}, 32'd320);
        chk("midrst_y", {22'd0, o_y}, 32'd240);
        chk("midrst_dir_x", {31'd0, dir_x}, 32'd1);
        chk("midrst_upd", 32'(upd_cnt), 32'(uc));

        // Long vsync: exactly one update per assertion
        frame(20, 0);
        chk("post_rst_deb_upd", 32'(upd_cnt), 32'(uc));
        push_exp(323, 240, 1, 1);
        frame(1000, 0);
        chk("long_vs_cnt", 32'(upd_cnt), 32'(uc + 1));
        chk("long_vs_x", {22'd0, o_x}, 32'd323);

        // step 0 freezes the object
        step = 3'd0;
        uc = upd_cnt;
        frame(20, 0);
        frame(20, 0);
        chk("frozen_x", {22'd0, o_x}, 32'd323);
        chk("frozen_upd", 32'(upd_cnt), 32'(uc));

        // Bounce from reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        btn = 4'd0; auto_mode = 1'b1; step = 3'd5;
        mx = 320; my = 240; mdx = 1; mdy = 1;
        for (int f = 1; f <= 58; f++) begin
            nx = (mdx != 0) ? mx + 5 : mx - 5;
            if (nx > 600) begin nx = 600; mdx = 0; end
            else if (nx < 10) begin nx = 10; mdx = 1; end
            ny = (mdy != 0) ? my + 5 : my - 5;
            if (ny > 440) begin ny = 440; mdy = 0; end
            else if (ny < 10) begin ny = 10; mdy = 1; end
            if (nx != mx || ny != my) push_exp(nx, ny, mdx, mdy);
            mx = nx; my = ny;
            frame(20, 0);
            if (f == 40) begin
                chk("bounce_f40_y", {22'd0, o_y}, 32'd440);
                chk("bounce_f40_dir_y", {31'd0, dir_y}, 32'd1);
            end
            if (f == 41) begin
                chk("bounce_f41_y", {22'd0, o_y}, 32'd440);
                chk("bounce_f41_dir_y", {31'd0, dir_y}, 32'd0);
            end
            if (f == 42) chk("bounce_f42_y", {22'd0, o_y}, 32'd435);
            if (f == 56) begin
                chk("bounce_f56_x", {22'd0, o_x}, 32'd600);
                chk("bounce_f56_dir_x", {31'd0, dir_x}, 32'd1);
            end
            if (f == 57) begin
                chk("bounce_f57_x", {22'd0, o_x}, 32'd600);
                chk("bounce_f57_dir_x", {31'd0, dir_x}, 32'd0);
            end
            if (f == 58) chk("bounce_f58_x", {22'd0, o_x}, 32'd595);
        end

        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
